// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the fetch stage; widths are also used by the
// shift/sign-extend stage and the ALU.
package instruction_fetch_unit_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: branch load has priority over the +4 increment.
// pc_next is exported so the fetch FSM can register the next read address.
module instruction_fetch_unit_program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_next = pc_q;
        if (load) begin
            pc_next = load_value & ALIGN_MASK;
        end else if (incr) begin
            // Wraps modulo 2^ADDR_W by construction.
            pc_next = pc_q + ADDR_W'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, memory read handshake, instruction register and
// branch redirect with stale-fetch flushing. All outputs are registered.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_WIDTH,
    parameter int unsigned       DATA_W   = DATA_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_moc,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC & ~ADDR_W'(WORD_BYTES - 1);

    fetch_state_e      state_q, state_d;
    logic              pc_load, pc_incr, ir_load;
    logic [ADDR_W-1:0] pc, pc_next;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] ir_pc_q;
    logic              ir_valid_q, ir_valid_d;

    instruction_fetch_unit_program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_ADDR)
    ) u_program_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (pc_load),
        .load_value (branch_target),
        .incr       (pc_incr),
        .pc         (pc),
        .pc_next    (pc_next)
    );

    always_comb begin
        state_d    = state_q;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;
        ir_load    = 1'b0;
        ir_valid_d = ir_valid_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                pc_load = branch_en;
            end
            StFetch: begin
                if (branch_en) begin
                    pc_load = 1'b1;
                    // Completed-but-stale data needs a one-cycle request gap via IDLE;
                    // an outstanding request must be drained first.
                    state_d = mem_moc ? StIdle : StDrain;
                end else if (mem_moc) begin
                    ir_load    = 1'b1;
                    pc_incr    = 1'b1;
                    ir_valid_d = 1'b1;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (branch_en || ir_ready) begin
                    pc_load    = branch_en;
                    ir_valid_d = 1'b0;
                    state_d    = StFetch;
                end
            end
            StDrain: begin
                pc_load = branch_en;
                if (mem_moc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        mem_rd_d   = (state_d == StFetch) || (state_d == StDrain);
        // The address of an outstanding request is frozen until its completion.
        mem_addr_d = (state_d == StDrain) ? mem_addr_q : pc_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            mem_addr_q <= RESET_ADDR;
            mem_rd_q   <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            ir_valid_q <= ir_valid_d;
            if (ir_load) begin
                ir_q    <= mem_data;
                ir_pc_q <= pc;
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a synchronous memory model feeds
// two instances (RESET_PC 0 and 0xFFFF_FFFC) selected one at a time.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        ir_ready;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        moc;
    logic        sel;
    logic [31:0] mem_data;

    logic [31:0] mem_addr0, mem_addr1, ir0, ir1, ir_pc0, ir_pc1;
    logic        mem_rd0, mem_rd1, ir_valid0, ir_valid1;
    logic        mem_moc0, mem_moc1;

    logic [31:0] cur_addr, cur_ir, cur_ir_pc;
    logic        cur_rd, cur_valid;

    int checks;
    int errors;
    int mem_wait;
    int discard;
    int valid_count;
    int cyc;
    logic chk_period, chk_len, chk_gap;

    logic [31:0] addr_q[$];
    logic [31:0] sb_ir[$];
    logic [31:0] sb_pc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[7:0], addr[31:8]} ^ 32'hC0DE_0000;
    endfunction

    assign cur_addr  = sel ? mem_addr1 : mem_addr0;
    assign cur_rd    = sel ? mem_rd1 : mem_rd0;
    assign cur_ir    = sel ? ir1 : ir0;
    assign cur_ir_pc = sel ? ir_pc1 : ir_pc0;
    assign cur_valid = sel ? ir_valid1 : ir_valid0;
    assign mem_moc0  = moc & ~sel;
    assign mem_moc1  = moc & sel;
    assign mem_data  = mem_word(cur_addr);

    instruction_fetch_unit u_dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr      (mem_addr0),
        .mem_rd        (mem_rd0),
        .mem_moc       (mem_moc0),
        .mem_data      (mem_data),
        .ir            (ir0),
        .ir_pc         (ir_pc0),
        .ir_valid      (ir_valid0),
        .ir_ready      (ir_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target)
    );

    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr      (mem_addr1),
        .mem_rd        (mem_rd1),
        .mem_moc       (mem_moc1),
        .mem_data      (mem_data),
        .ir            (ir1),
        .ir_pc         (ir_pc1),
        .ir_valid      (ir_valid1),
        .ir_ready      (ir_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Synchronous memory: moc appears mem_wait+1 cycles after the request is first seen.
    initial begin : memory
        int cnt;
        cnt = 0;
        moc = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || moc) begin
                moc = 1'b0;
                cnt = 0;
            end else if (cur_rd) begin
                if (cnt >= mem_wait + 1) begin
                    moc = 1'b1;
                    if (discard > 0) begin
                        discard--;
                    end else begin
                        sb_ir.push_back(mem_word(cur_addr));
                        sb_pc.push_back(cur_addr);
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        logic        prev_rd, prev_valid;
        logic [31:0] prev_addr, prev_ir, prev_ir_pc, exp_v;
        int          rd_len, gap_len, last_rise;
        prev_rd    = 1'b0;
        prev_valid = 1'b0;
        prev_addr  = '0;
        prev_ir    = '0;
        prev_ir_pc = '0;
        rd_len     = 0;
        gap_len    = 0;
        last_rise  = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                prev_rd    = 1'b0;
                prev_valid = 1'b0;
                rd_len     = 0;
                gap_len    = 0;
            end else begin
                if (cur_rd && !prev_rd) begin
                    check_eq("fetch_queued", 32'(addr_q.size() != 0), 32'd1);
                    if (addr_q.size() != 0) begin
                        exp_v = addr_q.pop_front();
                        check_eq("fetch_addr", cur_addr, exp_v);
                    end
                    if (chk_gap) check_eq("rd_gap", 32'(gap_len), 32'd1);
                    rd_len = 1;
                end else if (cur_rd) begin
                    check_eq("addr_stable", cur_addr, prev_addr);
                    rd_len++;
                end else if (prev_rd) begin
                    check_eq("rd_until_moc", 32'(moc), 32'd1);
                    if (chk_len) check_eq("rd_len", 32'(rd_len), 32'(mem_wait + 2));
                    gap_len = 1;
                end else begin
                    gap_len++;
                end

                if (cur_valid && !prev_valid) begin
                    check_eq("ir_after_moc", 32'(moc), 32'd1);
                    check_eq("sb_queued", 32'(sb_ir.size() != 0), 32'd1);
                    if (sb_ir.size() != 0) begin
                        exp_v = sb_ir.pop_front();
                        check_eq("ir_word", cur_ir, exp_v);
                        exp_v = sb_pc.pop_front();
                        check_eq("ir_pc", cur_ir_pc, exp_v);
                    end
                    if (chk_period && valid_count > 0)
                        check_eq("valid_period", 32'(cyc - last_rise), 32'd3);
                    last_rise = cyc;
                    valid_count++;
                end else if (cur_valid) begin
                    check_eq("ir_stable", cur_ir, prev_ir);
                    check_eq("ir_pc_stable", cur_ir_pc, prev_ir_pc);
                end

                prev_rd    = cur_rd;
                prev_valid = cur_valid;
                prev_addr  = cur_addr;
                prev_ir    = cur_ir;
                prev_ir_pc = cur_ir_pc;
            end
        end
    end

    task automatic do_reset(input logic new_sel);
        logic [31:0] rst_pc;
        rst_pc = new_sel ? 32'hFFFF_FFFC : 32'h0;
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        branch_en = 1'b0;
        sel       = new_sel;
        #1;
        check_eq("rst_mem_rd", 32'(cur_rd), 32'd0);
        check_eq("rst_ir_valid", 32'(cur_valid), 32'd0);
        check_eq("rst_ir", cur_ir, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_mem_addr", cur_addr, rst_pc);
        check_eq("rst_ir_pc", cur_ir_pc, 32'd0);
        addr_q.delete();
        sb_ir.delete();
        sb_pc.delete();
        discard     = 0;
        valid_count = 0;
        addr_q.push_back(rst_pc);
        reset_n = 1'b1;
        @(posedge clk);
        #3;
        check_eq("rst_idle_one_cycle", 32'(cur_rd), 32'd1);
    endtask

    task automatic wait_pulses(input int n);
        int k;
        k = 0;
        while (valid_count < n && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        check_eq("pulse_timeout", 32'(valid_count >= n), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        sel           = 1'b0;
        ir_ready      = 1'b1;
        branch_en     = 1'b0;
        branch_target = '0;
        mem_wait      = 0;
        discard       = 0;
        valid_count   = 0;
        chk_period    = 1'b0;
        chk_len       = 1'b1;
        chk_gap       = 1'b0;

        // Zero-wait memory, decode always ready.
        chk_period = 1'b1;
        do_reset(1'b0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        addr_q.push_back(32'hC);
        wait_pulses(3);
        chk_period = 1'b0;

        // Slow memory.
        mem_wait = 4;
        do_reset(1'b0);
        addr_q.push_back(32'h4);
        wait_pulses(1);

        // Backpressure from decode.
        mem_wait = 0;
        ir_ready = 1'b0;
        do_reset(1'b0);
        wait_pulses(1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            check_eq("bp_ir_valid", 32'(cur_valid), 32'd1);
            check_eq("bp_mem_rd", 32'(cur_rd), 32'd0);
            check_eq("bp_pc", cur_addr, 32'h4);
            check_eq("bp_ir", cur_ir, mem_word(32'h0));
        end
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        ir_ready = 1'b1;
        wait_pulses(2);

        // Branch while holding ir; the coincident ir_ready must be ignored.
        do_reset(1'b0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        wait_pulses(2);
        @(posedge clk);
        #2;
        ir_ready = 1'b0;
        wait_pulses(3);
        check_eq("hold_ir_pc", cur_ir_pc, 32'h8);
        branch_target = 32'h103;
        branch_en     = 1'b1;
        ir_ready      = 1'b1;
        addr_q.push_back(32'h100);
        @(posedge clk);
        #2;
        branch_en = 1'b0;
        check_eq("branch_drops_valid", 32'(cur_valid), 32'd0);
        addr_q.push_back(32'h104);
        wait_pulses(4);

        // Branch mid-fetch, two cycles before completion: stale word is drained.
        mem_wait = 3;
        do_reset(1'b0);
        chk_gap = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        branch_target = 32'h200;
        branch_en     = 1'b1;
        discard       = 1;
        addr_q.push_back(32'h200);
        @(posedge clk);
        #2;
        branch_en = 1'b0;
        check_eq("drain_addr_held", cur_addr, 32'h0);
        addr_q.push_back(32'h204);
        wait_pulses(1);
        chk_gap = 1'b0;

        // Wrap-around from RESET_PC=0xFFFF_FFFC, then reset mid-fetch.
        mem_wait = 0;
        do_reset(1'b1);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        wait_pulses(2);
        check_eq("wrap_ir_pc", cur_ir_pc, 32'h0);
        @(posedge clk);
        #2;
        do_reset(1'b1);

        @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
